// File: rtl/wb_port_arbiter.sv
// Purpose  : shares the single register-file write port between the pipeline WB stage
//            and queued multiply/divide results; the pipeline wins unless the MD head starves.
// Latency  : inputs sampled at edge N drive o_RF_* from edge N to edge N+1 (all outputs registered).
// Backpress: MD side uses valid/ready (o_MD_Ready from registered count); pipeline side is held via
//            o_Stall for one cycle per forced drain.
// Ports    : clk, rst_n (async active-low)
//            i_Sig_RegWrite/i_Write_Register/i_Sig_MemtoReg/i_Read_Data/i_ALU_Result : MEM/WB write request
//            i_MD_Valid/i_MD_Dest/i_MD_Result, o_MD_Ready                        : MD result push
//            o_Stall                                                             : hold WB inputs
//            o_RF_WE/o_RF_Addr/o_RF_Data                                         : register-file write port
module wb_port_arbiter #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 3,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_Sig_RegWrite,
   input  logic [ADDR_W-1:0] i_Write_Register,
   input  logic              i_Sig_MemtoReg,
   input  logic [DATA_W-1:0] i_Read_Data,
   input  logic [DATA_W-1:0] i_ALU_Result,
   input  logic              i_MD_Valid,
   input  logic [ADDR_W-1:0] i_MD_Dest,
   input  logic [DATA_W-1:0] i_MD_Result,
   output logic              o_MD_Ready,
   output logic              o_Stall,
   output logic              o_RF_WE,
   output logic [ADDR_W-1:0] o_RF_Addr,
   output logic [DATA_W-1:0] o_RF_Data
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_FORCE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AGE_W-1:0]  age_q, age_d, age_inc;
   logic              stall_q;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic [ADDR_W-1:0] fifo_dest_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

   logic              preq;
   logic [DATA_W-1:0] pipe_dat;
   logic              md_rdy;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] head_dest;
   logic [DATA_W-1:0] head_dat;
   logic              last_entry;

   always_comb begin
      preq      = i_Sig_RegWrite && (i_Write_Register != '0);
      pipe_dat  = i_Sig_MemtoReg ? i_Read_Data : i_ALU_Result;
      // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
      md_rdy    = (count_q < CNT_W'(FIFO_DEPTH));
      push      = i_MD_Valid && md_rdy;
      head_dest = fifo_dest_q[rd_ptr_q];
      head_dat  = fifo_data_q[rd_ptr_q];
      // FIFO drains to empty on this pop unless a push refills it in the same cycle.
      last_entry = (count_q == CNT_W'(1)) && !push;
      age_inc   = (age_q >= AGE_W'(STARVE_LIMIT)) ? AGE_W'(STARVE_LIMIT) : age_q + AGE_W'(1);

      state_d = state_q;
      age_d   = age_q;
      pop     = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;

      case (state_q)
         ST_IDLE: begin
            if (preq) begin
               we_d   = 1'b1;
               addr_d = i_Write_Register;
               data_d = pipe_dat;
            end
            if (push) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (preq) begin
               we_d   = 1'b1;
               addr_d = i_Write_Register;
               data_d = pipe_dat;
               age_d  = age_inc;
               if (age_inc == AGE_W'(STARVE_LIMIT)) state_d = ST_FORCE;
            end else begin
               pop   = 1'b1;
               age_d = '0;
               if (last_entry) state_d = ST_IDLE;
            end
         end
         ST_FORCE: begin
            // Pipeline inputs are ignored here; the stalled stage re-presents them next cycle.
            pop     = 1'b1;
            age_d   = '0;
            state_d = last_entry ? ST_IDLE : ST_PEND;
         end
         default: begin
            state_d = ST_IDLE;
            age_d   = '0;
         end
      endcase

      // An MD result aimed at R0 still uses its grant but writes nothing.
      if (pop && (head_dest != '0)) begin
         we_d   = 1'b1;
         addr_d = head_dest;
         data_d = head_dat;
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         age_q    <= '0;
         stall_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         age_q   <= age_d;
         stall_q <= (state_d == ST_FORCE);
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Entry storage needs no reset: count and pointers define which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dest_q[wr_ptr_q] <= i_MD_Dest;
         fifo_data_q[wr_ptr_q] <= i_MD_Result;
      end
   end

   assign o_MD_Ready = md_rdy;
   assign o_Stall    = stall_q;
   assign o_RF_WE    = we_q;
   assign o_RF_Addr  = addr_q;
   assign o_RF_Data  = data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Purpose  : self-checking bench for wb_port_arbiter with a cycle model feeding a scoreboard.
// Latency  : expectations are queued as each cycle is driven and compared #1 after the edge.
// Backpress: MD producer advances only on an accepted push; pipeline inputs held while stalled.
module tb_wb_port_arbiter;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int DEPTH = 2;
   localparam int LIMIT = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rw, mtr, mdv;
   logic [AW-1:0] wreg, mdd;
   logic [DW-1:0] rdat, alu, mdr;
   logic          md_rdy, stall, rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_dat;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_Sig_RegWrite(rw), .i_Write_Register(wreg), .i_Sig_MemtoReg(mtr),
      .i_Read_Data(rdat), .i_ALU_Result(alu),
      .i_MD_Valid(mdv), .i_MD_Dest(mdd), .i_MD_Result(mdr),
      .o_MD_Ready(md_rdy), .o_Stall(stall),
      .o_RF_WE(rf_we), .o_RF_Addr(rf_addr), .o_RF_Data(rf_dat)
   );

   typedef struct { logic [AW-1:0] dest; logic [DW-1:0] dat; } md_t;
   typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] dat; logic stall; logic rdy; } exp_t;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  n_we    = 0;
   // Reference model: 0 idle, 1 pending, 2 forced drain.
   int  m_state = 0;
   int  m_age   = 0;
   md_t mq[$];
   exp_t sb[$];
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_dat  = '0;
   bit  m_push_ok;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_state = 0;
      m_age   = 0;
      m_addr  = '0;
      m_dat   = '0;
   endtask

   // Predict the outputs after the coming edge, then sample and compare them.
   task automatic step();
      exp_t e;
      md_t  h;
      bit   preq, push, pop;
      int   nxt;
      preq = rw && (wreg != 0);
      push = mdv && (mq.size() < DEPTH);
      pop  = 0;
      nxt  = m_state;
      e.we = 0;
      if (m_state == 2 || (m_state == 1 && !preq)) begin
         pop   = 1;
         m_age = 0;
      end else if (preq) begin
         e.we   = 1;
         m_addr = wreg;
         m_dat  = mtr ? rdat : alu;
         if (m_state == 1) begin
            m_age = (m_age < LIMIT) ? m_age + 1 : LIMIT;
            if (m_age == LIMIT) nxt = 2;
         end
      end
      if (pop) begin
         h = mq.pop_front();
         if (h.dest != 0) begin
            e.we   = 1;
            m_addr = h.dest;
            m_dat  = h.dat;
         end
      end
      if (push) mq.push_back('{dest: mdd, dat: mdr});
      if (m_state == 0 && push) nxt = 1;
      if (pop) nxt = (mq.size() == 0) ? 0 : 1;
      e.addr    = m_addr;
      e.dat     = m_dat;
      e.stall   = (nxt == 2);
      e.rdy     = (mq.size() < DEPTH);
      m_state   = nxt;
      m_push_ok = push;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (rf_we === 1'b1) n_we++;
      chk("rf_we", rf_we, e.we);
      chk("stall", stall, e.stall);
      chk("md_rdy", md_rdy, e.rdy);
      if (e.we) begin
         chk("rf_addr", rf_addr, e.addr);
         chk("rf_dat", rf_dat, e.dat);
      end
   endtask

   task automatic idle_inputs();
      rw = 0; wreg = 0; mtr = 0; rdat = 0; alu = 0;
      mdv = 0; mdd = 0; mdr = 0;
   endtask

   initial begin
      int cnt;
      md_t items[$];
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", rf_we, 0);
      chk("rst_addr", rf_addr, 0);
      chk("rst_dat", rf_dat, 0);
      chk("rst_stall", stall, 0);
      chk("rst_rdy", md_rdy, 1);
      #3 rst_n = 1'b1;

      // Pipeline only: MemtoReg selects load data, then ALU, then R0 is not a request.
      rw = 1; wreg = 3; mtr = 1; rdat = 16'h1234; alu = 16'hBEEF;
      step();
      chk("pipe_load", rf_dat, 16'h1234);
      mtr = 0;
      step();
      chk("pipe_alu", rf_dat, 16'hBEEF);
      wreg = 0;
      step();
      chk("pipe_r0_we", rf_we, 0);
      idle_inputs();
      step();

      // MD only: retire one cycle after the push, FIFO back to empty.
      mdv = 1; mdd = 5; mdr = 16'h00AA;
      step();
      mdv = 0;
      step();
      chk("md_addr", rf_addr, 5);
      chk("md_dat", rf_dat, 16'h00AA);
      chk("md_rdy_empty", md_rdy, 1);

      // Starvation: head waits LIMIT pipeline writes, then a one-cycle forced drain.
      mdv = 1; mdd = 2; mdr = 16'h5555;
      step();
      mdv = 0;
      rw = 1; wreg = 4; alu = 16'h0100;
      cnt = 0;
      for (int i = 0; i < 10 && stall !== 1'b1; i++) begin
         step();
         if (rf_we === 1'b1 && rf_addr == 4) cnt++;
         if (stall !== 1'b1) alu = alu + 1;
      end
      chk("starve_pipe_writes", cnt, LIMIT);
      chk("starve_stall", stall, 1);
      step();
      chk("force_addr", rf_addr, 2);
      chk("force_dat", rf_dat, 16'h5555);
      chk("force_stall_1cyc", stall, 0);
      alu = alu + 1;
      step();
      chk("resume_addr", rf_addr, 4);

      // Full FIFO under continuous PREQ: third offer waits, all retire in order.
      items = '{'{dest: 6, dat: 16'h0601}, '{dest: 7, dat: 16'h0702}, '{dest: 1, dat: 16'h0103}};
      for (int i = 0; i < 30; i++) begin
         mdv = (items.size() != 0);
         if (items.size() != 0) begin
            mdd = items[0].dest;
            mdr = items[0].dat;
         end
         if (i == 20) rw = 0;
         if (stall !== 1'b1) alu = alu + 1;
         step();
         if (m_push_ok) void'(items.pop_front());
         if (i == 2) chk("full_rdy_low", md_rdy, 0);
      end
      chk("full_drained", items.size(), 0);
      idle_inputs();

      // MD entry to R0 is consumed without a write.
      mdv = 1; mdd = 0; mdr = 16'hFFFF;
      step();
      mdv = 0;
      step();
      chk("md_r0_we", rf_we, 0);
      step();

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         rw   = ($urandom_range(0, 3) != 0);
         wreg = AW'($urandom);
         mtr  = 1'($urandom);
         rdat = DW'($urandom);
         alu  = DW'($urandom);
         mdv  = ($urandom_range(0, 2) == 0);
         mdd  = AW'($urandom);
         mdr  = DW'($urandom);
         step();
      end
      idle_inputs();
      repeat (4) step();

      // Reset in the middle of a forced drain.
      rw = 1; wreg = 1; alu = 16'h0A0A;
      mdv = 1; mdd = 3; mdr = 16'h3333;
      step();
      mdd = 6; mdr = 16'h6666;
      step();
      mdv = 0;
      for (int i = 0; i < 10 && m_state != 2; i++) step();
      chk("pre_rst_stall", stall, 1);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("mrst_we", rf_we, 0);
      chk("mrst_addr", rf_addr, 0);
      chk("mrst_dat", rf_dat, 0);
      chk("mrst_stall", stall, 0);
      chk("mrst_rdy", md_rdy, 1);
      #1 rst_n = 1'b1;
      n_we = 0;
      rw = 1; wreg = 3; alu = 16'h0C0C;
      step();
      rw = 0;
      repeat (4) step();
      chk("post_rst_writes", n_we, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
